// File: rtl/score_seg_driver.sv
// Four-digit common-anode scan driver: player letter, blank, tens, ones.
// Optional macro BLINK_EN blinks the player digit for BLINK_FRAMES frames after a player change.
module score_seg_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int CNT_W        = 17,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [2:0] thousands,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  logic [CNT_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       snap_ones;
  logic [3:0]       snap_tens;
  logic [2:0]       player;
  logic [6:0]       digit_seg;
  logic             term;
  logic             wrap;
  logic             blank3;

  assign term = (div == CNT_W'(REFRESH_DIV - 1));
  assign wrap = term && (idx == 2'd3);
  assign dp   = 1'b1;

  function automatic logic [6:0] bcd_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_seg = 7'b1000000;
      4'd1:    bcd_seg = 7'b1111001;
      4'd2:    bcd_seg = 7'b0100100;
      4'd3:    bcd_seg = 7'b0110000;
      4'd4:    bcd_seg = 7'b0011001;
      4'd5:    bcd_seg = 7'b0010010;
      4'd6:    bcd_seg = 7'b0000010;
      4'd7:    bcd_seg = 7'b1111000;
      4'd8:    bcd_seg = 7'b0000000;
      4'd9:    bcd_seg = 7'b0010000;
      default: bcd_seg = 7'b0000110;
    endcase
  endfunction

`ifdef BLINK_EN
  localparam int BW = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;

  // Counter steps once per frame, at the same wrap that takes the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else if (wrap) begin
      if (thousands != player) blink_cnt <= BW'(BLINK_FRAMES);
      else if (blink_cnt != '0) blink_cnt <= blink_cnt - 1'b1;
    end
  end

  assign blank3 = (blink_cnt != '0) && blink_cnt[2];
`else
  assign blank3 = 1'b0;
`endif

  always_comb begin
    digit_seg = 7'h7F;
    case (idx)
      2'd0: digit_seg = bcd_seg(snap_ones);
      2'd1: digit_seg = (snap_tens == 4'd0) ? 7'h7F : bcd_seg(snap_tens);
      2'd2: digit_seg = 7'h7F;
      default: begin
        case (player)
          3'b100:  digit_seg = 7'b0001000;
          3'b010:  digit_seg = 7'b0000011;
          3'b001:  digit_seg = 7'b1000110;
          default: digit_seg = 7'b0111111;
        endcase
        if (blank3) digit_seg = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      idx         <= 2'd0;
      snap_ones   <= 4'd0;
      snap_tens   <= 4'd0;
      player      <= 3'b000;
      frame_start <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'h7F;
    end else begin
      if (term) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      frame_start <= wrap;
      // Tear-free: the bus is only looked at on the frame boundary.
      if (wrap) begin
        snap_ones <= ones;
        snap_tens <= tens;
        player    <= thousands;
      end
      an  <= ~(4'b0001 << idx);
      seg <= digit_seg;
    end
  end

endmodule
